// File: rtl/mmio_counter_bridge_pkg.sv
// Shared types and constants for the MMIO performance-counter window.
// Also used by the counter bank, so keep the base address and count in sync here.
package mmio_counter_bridge_pkg;

  localparam logic [15:0] MMIO_BASE_ADDR    = 16'hFFE0;
  localparam int unsigned MMIO_NUM_COUNTERS = 12;

  typedef logic [3:0] lc3b_counter_idx;

  // Bridge FSM encoding, kept as plain constants for older tools.
  typedef logic [1:0] lc3b_mmio_state;
  localparam lc3b_mmio_state IDLE   = 2'd0;
  localparam lc3b_mmio_state ACCESS = 2'd1;
  localparam lc3b_mmio_state RESP   = 2'd2;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational decode of a data access against a 32-byte, 16-entry MMIO window.
// Bit 0 of the byte address is dropped, so the port takes the word address only.
module mmio_addr_decode
  import mmio_counter_bridge_pkg::*;
#(
  parameter logic [15:0] BASE = MMIO_BASE_ADDR,
  parameter int unsigned NUM  = MMIO_NUM_COUNTERS
) (
  input  logic [14:0]     word_address,
  input  logic            read,
  input  logic            write,
  output logic            hit,
  output lc3b_counter_idx idx,
  output logic            valid
);

  localparam logic [4:0] NUM_LIMIT = 5'(NUM);

  assign hit   = (read | write) & (word_address[14:4] == BASE[15:5]);
  assign idx   = word_address[3:0];
  assign valid = ({1'b0, idx} < NUM_LIMIT);

endmodule

// File: rtl/mmio_counter_bridge.sv
// MEM-stage bridge: counter-window accesses go to the counter bank with a
// registered response two cycles later; everything else passes to the D-cache.
module mmio_counter_bridge
  import mmio_counter_bridge_pkg::*;
#(
  parameter logic [15:0] MMIO_BASE    = MMIO_BASE_ADDR,
  parameter int unsigned NUM_COUNTERS = MMIO_NUM_COUNTERS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        dcache_read,
  output logic        dcache_write,
  output logic [15:0] dcache_address,
  output logic [15:0] dcache_wdata,
  input  logic [15:0] dcache_rdata,
  input  logic        dcache_resp,
  output logic [3:0]  counter,
  output logic        MMIO_read,
  output logic        MMIO_write,
  input  logic [15:0] counter_out
);

  lc3b_mmio_state  state;
  lc3b_counter_idx idx_reg;
  logic            is_wr_reg;
  logic            valid_reg;
  logic [15:0]     rdata_reg;

  logic            hit;
  lc3b_counter_idx idx;
  logic            valid;

  mmio_addr_decode #(
    .BASE (MMIO_BASE),
    .NUM  (NUM_COUNTERS)
  ) u_decode (
    .word_address (mem_address[15:1]),
    .read         (mem_read),
    .write        (mem_write),
    .hit          (hit),
    .idx          (idx),
    .valid        (valid)
  );

  // Index validity is latched with the index so ACCESS needs no second compare.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx_reg   <= '0;
      is_wr_reg <= 1'b0;
      valid_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            idx_reg   <= idx;
            is_wr_reg <= mem_write;
            valid_reg <= valid;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_reg <= valid_reg ? counter_out : 16'h0000;
          state     <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dcache_address = mem_address;
    dcache_wdata   = mem_wdata;
    counter        = idx_reg;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    mem_resp       = 1'b0;
    mem_rdata      = 16'h0000;
    MMIO_read      = 1'b0;
    MMIO_write     = 1'b0;
    case (state)
      IDLE: begin
        dcache_read  = mem_read & ~hit;
        dcache_write = mem_write & ~hit;
        mem_resp     = dcache_resp & ~hit;
        mem_rdata    = hit ? 16'h0000 : dcache_rdata;
      end
      ACCESS: begin
        MMIO_write = valid_reg & is_wr_reg;
        MMIO_read  = valid_reg & ~is_wr_reg;
      end
      RESP: begin
        mem_resp  = 1'b1;
        mem_rdata = rdata_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmio_counter_bridge.sv
// Scoreboard bench for mmio_counter_bridge: stimulus pushes expected strobes and
// responses, a negedge monitor pops and compares; a modelled counter bank drives counter_out.
module tb_mmio_counter_bridge;

  logic        clk;
  logic        reset_n;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        dcache_read;
  logic        dcache_write;
  logic [15:0] dcache_address;
  logic [15:0] dcache_wdata;
  logic [15:0] dcache_rdata;
  logic        dcache_resp;
  logic [3:0]  counter;
  logic        MMIO_read;
  logic        MMIO_write;
  logic [15:0] counter_out;

  mmio_counter_bridge dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .counter        (counter),
    .MMIO_read      (MMIO_read),
    .MMIO_write     (MMIO_write),
    .counter_out    (counter_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct { int cyc; logic [15:0] rdata; bit chk; } resp_t;
  typedef struct { bit wr; logic [3:0] idx; } strobe_t;
  resp_t   resp_q[$];
  strobe_t strobe_q[$];
  resp_t   mon_r;
  strobe_t mon_s;

  // Counter bank model: a slot reads 0 once its clear generation catches up
  // with its preset generation; presets are owned by stimulus, clears by the monitor.
  logic [15:0] preset  [16];
  int          pre_gen [16];
  int          clr_gen [16];
  logic [15:0] ref_bank[16];
  assign counter_out = (clr_gen[counter] == pre_gen[counter]) ? 16'h0000 : preset[counter];

  logic [3:0] last_idx;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setCounter(input int i, input logic [15:0] val);
    preset[i]   = val;
    pre_gen[i]  = pre_gen[i] + 1;
    ref_bank[i] = val;
  endtask

  // Issues one held request starting just after a rising edge and returns just
  // after the edge following its response, with the request dropped.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wdata, input int lat, input logic [15:0] dc_rdata);
    int         c0;
    logic [3:0] idx;
    resp_t      r;
    strobe_t    s;
    c0  = cyc;
    idx = addr[4:1];
    if (addr[15:5] == 11'h7FF) begin
      if (idx < 12) begin
        s.wr = wr;
        s.idx = idx;
        strobe_q.push_back(s);
      end
      r.cyc   = c0 + 2;
      r.rdata = (idx < 12) ? ref_bank[idx] : 16'h0000;
      r.chk   = !wr;
      resp_q.push_back(r);
      if (wr && idx < 12) ref_bank[idx] = 16'h0000;
      mem_address = addr; mem_read = rd; mem_write = wr; mem_wdata = wdata;
      #1;
      checkOutput("mmio_c0_dcache_rd", dcache_read, 0);
      checkOutput("mmio_c0_dcache_wr", dcache_write, 0);
      checkOutput("mmio_c0_resp", mem_resp, 0);
      @(posedge clk); #1;
      checkOutput("mmio_c1_counter", counter, idx);
      checkOutput("mmio_c1_dcache", dcache_read | dcache_write, 0);
      @(posedge clk); #1;
      checkOutput("mmio_c2_dcache", dcache_read | dcache_write, 0);
      @(posedge clk); #1;
      last_idx = idx;
    end else begin
      r.cyc = c0 + lat; r.rdata = dc_rdata; r.chk = 1'b1;
      resp_q.push_back(r);
      mem_address = addr; mem_read = rd; mem_write = wr; mem_wdata = wdata;
      dcache_resp  = (lat == 0);
      dcache_rdata = (lat == 0) ? dc_rdata : 16'h0000;
      #1;
      checkOutput("pass_dcache_rd", dcache_read, rd);
      checkOutput("pass_dcache_wr", dcache_write, wr);
      checkOutput("pass_address", dcache_address, addr);
      checkOutput("pass_wdata", dcache_wdata, wdata);
      if (lat > 0) begin
        repeat (lat) @(posedge clk);
        #1;
        dcache_resp = 1'b1; dcache_rdata = dc_rdata;
      end
      checkOutput("pass_counter_held", counter, last_idx);
      @(posedge clk); #1;
      dcache_resp = 1'b0; dcache_rdata = 16'h0000;
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Monitor: every strobe and every response must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (MMIO_read || MMIO_write) begin
        if (strobe_q.size() == 0) begin
          checkOutput("unexpected_strobe", {30'd0, MMIO_write, MMIO_read}, 0);
        end else begin
          mon_s = strobe_q.pop_front();
          checkOutput("strobe_write", MMIO_write, mon_s.wr);
          checkOutput("strobe_read", MMIO_read, !mon_s.wr);
          checkOutput("strobe_index", counter, mon_s.idx);
        end
        if (MMIO_write && counter < 12) clr_gen[counter] = pre_gen[counter];
      end
      if (mem_resp) begin
        if (resp_q.size() == 0) begin
          checkOutput("unexpected_resp", mem_resp, 0);
        end else begin
          mon_r = resp_q.pop_front();
          checkOutput("resp_cycle", cyc, mon_r.cyc);
          if (mon_r.chk) checkOutput("resp_rdata", mem_rdata, mon_r.rdata);
        end
      end
    end
  end

  initial begin
    int          op;
    logic [15:0] a;
    logic [3:0]  ri;
    resp_t       r;
    strobe_t     s;
    reset_n = 1'b0;
    mem_address = 16'h0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = 16'h0;
    dcache_rdata = 16'h0; dcache_resp = 1'b0;
    last_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      preset[i]   = 16'($urandom) | 16'h0001;
      pre_gen[i]  = 1;
      clr_gen[i]  = 0;
      ref_bank[i] = preset[i];
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_mem_resp", mem_resp, 0);
    checkOutput("reset_mem_rdata", mem_rdata, 0);
    checkOutput("reset_mmio_read", MMIO_read, 0);
    checkOutput("reset_mmio_write", MMIO_write, 0);
    checkOutput("reset_counter", counter, 0);
    checkOutput("reset_dcache_read", dcache_read, 0);
    checkOutput("reset_dcache_write", dcache_write, 0);
    reset_n = 1'b1;

    setCounter(3, 16'h0042);
    applyStimulus(1'b1, 1'b0, 16'hFFE6, 16'h0000, 0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'hFFE4, 16'hBEEF, 0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0000, 5, 16'hA5A5);
    applyStimulus(1'b1, 1'b0, 16'hFFFA, 16'h0000, 0, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'hFFE0, 16'h1111, 0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'hFFE0, 16'h0000, 0, 16'h0000);

    // Reset lands at the end of ACCESS: the strobe already fired, no response follows.
    setCounter(5, 16'h5A5A);
    s.wr = 1'b0; s.idx = 4'd5;
    strobe_q.push_back(s);
    mem_address = 16'hFFEA; mem_read = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_mmio_read", MMIO_read, 0);
    checkOutput("abort_mem_resp", mem_resp, 0);
    reset_n = 1'b1;
    mem_read = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'hFFEA, 16'h0000, 0, 16'h0000);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) setCounter(int'($urandom_range(0, 15)), 16'($urandom));
      op = int'($urandom_range(0, 5));
      ri = 4'($urandom_range(0, 15));
      a  = {11'h7FF, ri, 1'($urandom)};
      case (op)
        0, 1: applyStimulus(1'b1, 1'b0, a, 16'($urandom), 0, 16'h0000);
        2:    applyStimulus(1'b0, 1'b1, a, 16'($urandom), 0, 16'h0000);
        3:    applyStimulus(1'b1, 1'b1, a, 16'($urandom), 0, 16'h0000);
        default: begin
          a = 16'($urandom);
          if (a[15:5] == 11'h7FF) a[14] = 1'b0;
          applyStimulus(op == 4, op == 5, a, 16'($urandom),
                        int'($urandom_range(0, 5)), 16'($urandom));
        end
      endcase
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++)
      checkOutput("bank_final", (clr_gen[i] == pre_gen[i]) ? 16'h0000 : preset[i], ref_bank[i]);
    checkOutput("strobes_outstanding", strobe_q.size(), 0);
    checkOutput("resps_outstanding", resp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
